program_sequencer: RTL and testbench

//  Upstream driver for the processor core: walks ROM addresses on Din and pulses run once per

---
 rtl/program_sequencer.sv | 160 ++++++++++++++++
 tb/tb_program_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// Program sequencer: walks ROM addresses on Din and issues one run pulse per instruction.
// Define SEQ_TIMEOUT_EN to add a WAIT_DONE watchdog and the ERR state.
module program_sequencer #(
    parameter int ADDR_W         = 5,
    parameter int START_ADDR     = 0,
    parameter int LAST_ADDR      = 31,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              step_mode,
    input  logic              step,
    input  logic              halt_req,
    input  logic              done,
    output logic [ADDR_W-1:0] Din,
    output logic              run,
    output logic              busy,
    output logic              finished,
    output logic              error,
    output logic [CNT_W-1:0]  instr_count
);

    if (LAST_ADDR < START_ADDR || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("program_sequencer: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        ADVANCE,
        PAUSE,
        HALTED
`ifdef SEQ_TIMEOUT_EN
        , ERR
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  din_q, din_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               run_q, run_d;
    logic               busy_q, busy_d;
    logic               finished_q, finished_d;

`ifdef SEQ_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               error_q, error_d;
`endif

    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        cnt_d   = cnt_q;
`ifdef SEQ_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) state_d = ISSUE;
            end
            ISSUE: begin
                state_d = WAIT_DONE;
`ifdef SEQ_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            WAIT_DONE: begin
                if (done) begin
                    state_d = ADVANCE;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    state_d = ERR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            ADVANCE: begin
                if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                // Din stays on the final address so the halted program is visible.
                if (din_q == ADDR_W'(LAST_ADDR) || halt_req) begin
                    state_d = HALTED;
                end else begin
                    din_d   = din_q + ADDR_W'(1);
                    state_d = step_mode ? PAUSE : ISSUE;
                end
            end
            PAUSE: begin
                if (halt_req)                state_d = HALTED;
                else if (step || !step_mode) state_d = ISSUE;
            end
`ifdef SEQ_TIMEOUT_EN
            HALTED, ERR: begin
`else
            HALTED: begin
`endif
                if (start) begin
                    state_d = ISSUE;
                    din_d   = ADDR_W'(START_ADDR);
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are decoded from the next state so they register alongside it.
        run_d      = (state_d == ISSUE);
        busy_d     = (state_d == ISSUE) || (state_d == WAIT_DONE) ||
                     (state_d == ADVANCE) || (state_d == PAUSE);
        finished_d = (state_d == HALTED);
`ifdef SEQ_TIMEOUT_EN
        error_d    = (state_d == ERR);
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            din_q      <= ADDR_W'(START_ADDR);
            cnt_q      <= '0;
            run_q      <= 1'b0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            tmo_q      <= '0;
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            din_q      <= din_d;
            cnt_q      <= cnt_d;
            run_q      <= run_d;
            busy_q     <= busy_d;
            finished_q <= finished_d;
`ifdef SEQ_TIMEOUT_EN
            tmo_q      <= tmo_d;
            error_q    <= error_d;
`endif
        end
    end

    assign Din         = din_q;
    assign run         = run_q;
    assign busy        = busy_q;
    assign finished    = finished_q;
    assign instr_count = cnt_q;
`ifdef SEQ_TIMEOUT_EN
    assign error       = error_q;
`else
    assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// Testbench for program_sequencer: a core model answers run with done, and a scoreboard
// queue holds the Din expected on every run pulse.
module tb_program_sequencer;
   localparam int ADDR_W = 5;
   localparam int CNT_W  = 8;
   localparam int START  = 0;
   localparam int LAST   = 3;
   localparam int TMO    = 8;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic              stepMode = 1'b0;
   logic              step = 1'b0;
   logic              haltReq = 1'b0;
   logic              done = 1'b0;
   logic [ADDR_W-1:0] Din;
   logic              run;
   logic              busy;
   logic              finished;
   logic              error;
   logic [CNT_W-1:0]  instrCount;

   int                total = 0;
   int                bad = 0;
   logic [31:0]       expQ[$];
   bit                coreEn = 1'b1;
   int                pend = 0;

   program_sequencer #(
      .ADDR_W(ADDR_W), .START_ADDR(START), .LAST_ADDR(LAST),
      .CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .step_mode(stepMode),
      .step(step), .halt_req(haltReq), .done(done), .Din(Din), .run(run),
      .busy(busy), .finished(finished), .error(error), .instr_count(instrCount)
   );

   // Free-running clock
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] want);
      total++;
      if (actual !== want) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, want);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic sm, input logic st, input logic h);
      @(negedge clock);
      start    = s;
      stepMode = sm;
      step     = st;
      haltReq  = h;
   endtask

   task automatic waitFinished(input string name, input int maxCyc);
      int n = 0;
      while (finished !== 1'b1 && n < maxCyc) begin
         @(negedge clock);
         n++;
      end
      checkOutput(name, 32'(finished), 1);
   endtask

   task automatic waitDin(input string name, input int val, input int maxCyc);
      int n = 0;
      while (Din !== ADDR_W'(val) && n < maxCyc) begin
         @(negedge clock);
         n++;
      end
      checkOutput(name, 32'(Din), 32'(val));
   endtask

   task automatic waitRunDin(input string name, input int val, input int maxCyc);
      int n = 0;
      while (!(run === 1'b1 && Din === ADDR_W'(val)) && n < maxCyc) begin
         @(negedge clock);
         n++;
      end
      checkOutput(name, 32'(Din), 32'(val));
      checkOutput({name, "_run"}, 32'(run), 1);
   endtask

   // Core model: done pulses for one cycle, four cycles after run is seen
   initial begin
      forever begin
         @(negedge clock);
         done = 1'b0;
         if (!reset) begin
            pend = 0;
         end else begin
            if (pend > 0) begin
               pend--;
               if (pend == 0) done = 1'b1;
            end
            if (run && coreEn) pend = 4;
         end
      end
   end

   // Monitor: every run pulse must be one cycle wide and carry the next queued address
   initial begin
      logic prevRun = 1'b0;
      forever begin
         @(negedge clock);
         if (run === 1'b1) begin
            checkOutput("run_width", 32'(prevRun), 0);
            if (expQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL run_unexpected: got run with Din=%0d expected no run", Din);
            end else begin
               checkOutput("run_din", 32'(Din), expQ.pop_front());
            end
         end
         prevRun = run;
      end
   end

   // Directed test sequence
   initial begin
      repeat (2) @(negedge clock);
      checkOutput("rst_din", 32'(Din), START);
      checkOutput("rst_run", 32'(run), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_finished", 32'(finished), 0);
      checkOutput("rst_error", 32'(error), 0);
      checkOutput("rst_count", 32'(instrCount), 0);
      reset = 1'b1;

      // Free run over addresses 0..3
      for (int i = 0; i <= LAST; i++) expQ.push_back(32'(i));
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      waitFinished("free_finished", 100);
      checkOutput("free_count", 32'(instrCount), 4);
      checkOutput("free_din", 32'(Din), 3);
      checkOutput("free_busy", 32'(busy), 0);

      // Restart from HALTED, then halt request while waiting at Din=2
      expQ.push_back(0); expQ.push_back(1); expQ.push_back(2);
      @(negedge clock);
      start = 1'b1;
      @(posedge clock); #1;
      checkOutput("restart_run", 32'(run), 1);
      checkOutput("restart_din", 32'(Din), START);
      checkOutput("restart_count", 32'(instrCount), 0);
      checkOutput("restart_finished", 32'(finished), 0);
      @(negedge clock);
      start = 1'b0;
      waitRunDin("halt_reach", 2, 60);
      haltReq = 1'b1;
      waitFinished("halt_finished", 60);
      checkOutput("halt_din", 32'(Din), 2);
      checkOutput("halt_count", 32'(instrCount), 3);
      haltReq = 1'b0;

      // Single-step mode
      expQ.push_back(0);
      applyStimulus(1, 1, 0, 0);
      applyStimulus(0, 1, 0, 0);
      waitDin("step_pause1", 1, 40);
      repeat (5) @(negedge clock);
      checkOutput("step_paused_run", 32'(run), 0);
      checkOutput("step_paused_busy", 32'(busy), 1);
      checkOutput("step_paused_din", 32'(Din), 1);
      checkOutput("step_paused_count", 32'(instrCount), 1);
      expQ.push_back(1);
      step = 1'b1;
      @(negedge clock);
      step = 1'b0;
      checkOutput("step_run", 32'(run), 1);
      waitDin("step_pause2", 2, 40);
      expQ.push_back(2); expQ.push_back(3);
      stepMode = 1'b0;
      waitFinished("step_finished", 80);
      checkOutput("step_count", 32'(instrCount), 4);

      // Asynchronous reset in the middle of WAIT_DONE at Din=1
      expQ.push_back(0); expQ.push_back(1);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      waitRunDin("midrst_reach", 1, 40);
      @(posedge clock);
      @(posedge clock); #2;
      reset = 1'b0;
      #1;
      checkOutput("midrst_din", 32'(Din), START);
      checkOutput("midrst_run", 32'(run), 0);
      checkOutput("midrst_busy", 32'(busy), 0);
      checkOutput("midrst_finished", 32'(finished), 0);
      checkOutput("midrst_error", 32'(error), 0);
      checkOutput("midrst_count", 32'(instrCount), 0);
      @(negedge clock);
      reset = 1'b1;
      repeat (10) @(negedge clock);
      checkOutput("midrst_idle_busy", 32'(busy), 0);

      // Core never answers
      coreEn = 1'b0;
      expQ.push_back(0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("tmo_issue_run", 32'(run), 1);
`ifdef SEQ_TIMEOUT_EN
      repeat (TMO) @(negedge clock);
      checkOutput("tmo_pre_error", 32'(error), 0);
      checkOutput("tmo_pre_busy", 32'(busy), 1);
      @(negedge clock);
      checkOutput("tmo_error", 32'(error), 1);
      checkOutput("tmo_run", 32'(run), 0);
      checkOutput("tmo_busy", 32'(busy), 0);
      checkOutput("tmo_din", 32'(Din), START);
      repeat (5) @(negedge clock);
      checkOutput("tmo_error_held", 32'(error), 1);
      coreEn = 1'b1;
      for (int i = 0; i <= LAST; i++) expQ.push_back(32'(i));
      @(negedge clock);
      start = 1'b1;
      @(posedge clock); #1;
      checkOutput("tmo_recover_run", 32'(run), 1);
      checkOutput("tmo_recover_error", 32'(error), 0);
      checkOutput("tmo_recover_count", 32'(instrCount), 0);
      @(negedge clock);
      start = 1'b0;
      waitFinished("tmo_recover_finished", 100);
      checkOutput("tmo_recover_final_count", 32'(instrCount), 4);
`else
      repeat (100) @(negedge clock);
      checkOutput("notmo_error", 32'(error), 0);
      checkOutput("notmo_busy", 32'(busy), 1);
      checkOutput("notmo_run", 32'(run), 0);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      coreEn = 1'b1;
      @(negedge clock);
      checkOutput("notmo_reset_busy", 32'(busy), 0);
`endif

      repeat (3) @(negedge clock);
      checkOutput("sb_empty", 32'(expQ.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
